serial_alu_seq: RTL and testbench

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/serial_alu_seq.sv | 120 ++++++++++++
 tb/tb_serial_alu_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds operands one bit per cycle, LSB first, through
// an external combinational 1-bit ALU slice and assembles the result and carry.
module serial_alu_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       select,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  output logic [2:0]       slice_select,
  input  logic             slice_out,
  input  logic             slice_cout
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [IDX_W-1:0] idx_q,    idx_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [2:0]       sel_q,    sel_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q,   cout_d;
  logic             zero_q,   zero_d;
  logic             running;

  assign running = (state_q == S_RUN);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start directly so back-to-back operations have no bubble
        if (start) begin
          state_d = S_RUN;
          idx_d   = '0;
          a_d     = a;
          b_d     = b;
          sel_d   = select;
          carry_d = carry_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[idx_q] = slice_out;
        carry_d         = slice_cout;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          cout_d  = sel_q[2] & slice_cout;
          zero_d  = (result_d == '0);
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign busy         = running;
  assign done         = (state_q == S_DONE);
  assign result       = result_q;
  assign carry_out    = cout_q;
  assign zero         = zero_q;
  assign slice_a      = running & a_q[idx_q];
  assign slice_b      = running & b_q[idx_q];
  assign slice_cin    = running & carry_q;
  assign slice_select = sel_q;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Bench for serial_alu_seq: arithmetic reference model checked every cycle, plus
// directed operations with literal expected results.
module tb_serial_alu_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0]   sel = '0;
  logic         cin = 1'b0;
  logic         busy, done, carry_out, zero;
  logic [W-1:0] result;
  logic         slice_a, slice_b, slice_cin, slice_out, slice_cout;
  logic [2:0]   slice_select;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .select(sel),
    .carry_in(cin), .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .zero(zero), .slice_a(slice_a), .slice_b(slice_b),
    .slice_cin(slice_cin), .slice_select(slice_select),
    .slice_out(slice_out), .slice_cout(slice_cout)
  );

  always #5 clk = ~clk;

  // External slice: 100 = full add, 011 = AND, anything else = OR
  always_comb begin
    slice_out  = slice_a | slice_b;
    slice_cout = 1'b0;
    case (slice_select)
      3'b100: begin
        slice_out  = slice_a ^ slice_b ^ slice_cin;
        slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
      end
      3'b011: slice_out = slice_a & slice_b;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic [2:0] s, input logic c,
                               output logic [W-1:0] r, output logic co);
    logic [W:0] sum;
    co = 1'b0;
    if (s == 3'b100) begin
      sum = {1'b0, x} + {1'b0, y} + (W+1)'(c);
      r   = sum[W-1:0];
      co  = sum[W];
    end else if (s == 3'b011) begin
      r = x & y;
    end else begin
      r = x | y;
    end
  endfunction

  // Carry entering bit i of an addition: carry out of the i-bit sum of the low bits
  function automatic logic add_cin(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input int i);
    logic [W:0]   s;
    logic [W-1:0] m;
    m = (W'(1) << i) - W'(1);
    s = {1'b0, x & m} + {1'b0, y & m} + (W+1)'(c);
    return s[i];
  endfunction

  int           m_cnt = 0;
  logic         m_done = 1'b0, m_cout = 1'b0, m_zero = 1'b1, p_cout, m_cin = 1'b0;
  logic [W-1:0] m_res = '0, p_res, m_a = '0, m_b = '0;
  logic [2:0]   m_sel = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_cnt = 0; m_done = 1'b0; m_res = '0; m_cout = 1'b0; m_zero = 1'b1;
      m_a = '0; m_b = '0; m_sel = '0; m_cin = 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt--;
      m_done = (m_cnt == 0);
      if (m_cnt == 0) begin
        m_res = p_res; m_cout = p_cout; m_zero = (p_res == '0);
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_a = a; m_b = b; m_sel = sel; m_cin = cin;
        calc(a, b, sel, cin, p_res, p_cout);
        m_cnt = W;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("busy", busy, m_cnt != 0);
      check("done", done, m_done);
      check("carry_out", carry_out, m_cout);
      check("zero", zero, m_zero);
      check("slice_select", slice_select, m_sel);
      if (m_cnt == 0) begin
        check("result", result, m_res);
        check("slice_idle", {slice_a, slice_b, slice_cin}, 3'b000);
      end else begin
        check("slice_a", slice_a, m_a[W - m_cnt]);
        check("slice_b", slice_b, m_b[W - m_cnt]);
        if (m_sel == 3'b100)
          check("slice_cin", slice_cin, add_cin(m_a, m_b, m_cin, W - m_cnt));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] s,
                        input logic c, input bit mid_start,
                        output logic [W-1:0] r, output logic co, output logic z,
                        output int lat, output int busy_n, output int done_n,
                        output logic [W-1:0] cins);
    int t0;
    @(posedge clk); #1;
    a = x; b = y; sel = s; cin = c; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1; busy_n = 0; done_n = 0; cins = '0; r = '0; co = 1'b0; z = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (mid_start) start = (i == 1);
      if (busy) begin
        if (busy_n < W) cins[busy_n] = slice_cin;
        busy_n++;
      end
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = cyc - t0; r = result; co = carry_out; z = zero;
        end
      end
    end
    start = 1'b0;
    check("done_seen", lat >= 0, 1);
  endtask

  logic [W-1:0] r, cins, res0, res1;
  logic         co, z, co0, co1;
  int           lat, busy_n, done_n, t0, d0, d1, nd;

  initial begin
    repeat (3) @(posedge clk);
    mon_en = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 1);
    check("rst_cout", carry_out, 0);

    run_op(4'h7, 4'h5, 3'b100, 1'b0, 1'b0, r, co, z, lat, busy_n, done_n, cins);
    check("add75_result", r, 4'hC);
    check("add75_cout", co, 0);
    check("add75_zero", z, 0);
    check("add75_latency", lat, 5);
    check("add75_busy_cycles", busy_n, 4);
    check("add75_done_pulses", done_n, 1);

    run_op(4'hF, 4'h1, 3'b100, 1'b0, 1'b0, r, co, z, lat, busy_n, done_n, cins);
    check("addF1_result", r, 4'h0);
    check("addF1_cout", co, 1);
    check("addF1_zero", z, 1);
    check("addF1_cin_seq", cins, 4'b1110);

    run_op(4'hC, 4'hA, 3'b011, 1'b0, 1'b1, r, co, z, lat, busy_n, done_n, cins);
    check("andCA_result", r, 4'h8);
    check("andCA_cout", co, 0);
    check("andCA_done_pulses", done_n, 1);
    check("andCA_latency", lat, 5);

    run_op(4'h3, 4'h4, 3'b100, 1'b1, 1'b0, r, co, z, lat, busy_n, done_n, cins);
    check("add34c_result", r, 4'h8);

    // Back-to-back: start held high, operands swapped after the first accept
    @(posedge clk); #1;
    a = 4'h3; b = 4'h9; sel = 3'b100; cin = 1'b0; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    a = 4'h6; b = 4'hB;
    nd = 0; d0 = -1; d1 = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (nd == 1 && busy) start = 1'b0;
      if (done) begin
        if (nd == 0) begin d0 = cyc; res0 = result; co0 = carry_out; end
        else if (nd == 1) begin d1 = cyc; res1 = result; co1 = carry_out; end
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", nd, 2);
    check("b2b_first_latency", d0 - t0, 5);
    check("b2b_spacing", d1 - d0, 5);
    check("b2b_res0", res0, 4'hC);
    check("b2b_cout0", co0, 0);
    check("b2b_res1", res1, 4'h1);
    check("b2b_cout1", co1, 1);

    // Reset in the 2nd RUN cycle, with a competing start, then an immediate restart
    @(posedge clk); #1;
    a = 4'h9; b = 4'h3; sel = 3'b100; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a = 4'h2; b = 4'h2; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_zero", zero, 1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done && lat < 0) begin lat = cyc - t0; r = result; end
    end
    check("restart_latency", lat, 5);
    check("restart_result", r, 4'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
